// File: rtl/pattern_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package pattern_det_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, ARMED = 2'd2} state_e;

  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

  // B,B,C,B,C with the first received bit in the MSB
  localparam logic [4:0] PAT_INIT_DEF = {B, B, C, B, C};
endpackage

// File: rtl/pattern_det_sat_cnt.sv
// Saturating event counter; clear beats increment.
module pattern_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pattern_det_param.sv
// Serial bit-pattern detector with loadable pattern, overlap control and match counter.
module pattern_det_param
  import pattern_det_pkg::*;
#(
  parameter int                 PAT_LEN  = 5,
  parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(PAT_INIT_DEF),
  parameter int                 CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_i,
  input  logic               valid_i,
  input  logic               overlap_i,
  input  logic               cfg_load_i,
  input  logic [PAT_LEN-1:0] cfg_pattern_i,
  input  logic               cnt_clr_i,
  output logic               pattern_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               busy_o
);
  localparam int            FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n, pat_q, pat_d;
  logic [FW-1:0]      fill_q, fill_d, fill_n;
  state_e             state_q, state_d;
  logic               hit_q, hit_d;

  always_comb begin
    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    state_d = state_q;
    hit_d   = 1'b0;
    hist_n  = {hist_q[PAT_LEN-2:0], d_i};
    fill_n  = (fill_q == FULL) ? FULL : fill_q + 1'b1;

    // A load restarts the search; any bit presented alongside it is discarded
    if (cfg_load_i) begin
      pat_d   = cfg_pattern_i;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (valid_i) begin
      hist_d = hist_n;
      fill_d = fill_n;
      if (hist_n == pat_q && fill_n == FULL) begin
        hit_d = 1'b1;
        if (!overlap_i) fill_d = '0;
      end
      case (state_q)
        EMPTY, FILLING, ARMED:
          state_d = (fill_d == '0)   ? EMPTY :
                    (fill_d == FULL) ? ARMED : FILLING;
        default: begin
          state_d = EMPTY;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      pat_q   <= PAT_INIT;
      fill_q  <= '0;
      state_q <= EMPTY;
      hit_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  pattern_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_d),
    .clr   (cnt_clr_i),
    .cnt_o (match_cnt_o)
  );

  assign pattern_o = hit_q;
  assign busy_o    = (state_q != EMPTY);
endmodule

// File: tb/tb_pattern_det_param.sv
// Bench: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_pattern_det_param;
  localparam logic [4:0] PINIT = 5'b00101;

  logic       clk = 1'b0;
  logic       rst = 1'b1, d_i = 1'b0, valid_i = 1'b0, overlap_i = 1'b0;
  logic       cfg_load_i = 1'b0, cnt_clr_i = 1'b0;
  logic [4:0] cfg_pattern_i = 5'b0;
  logic       p8, b8, p2, b2;
  logic [7:0] c8;
  logic [1:0] c2;

  always #5 clk = ~clk;

  pattern_det_param u_dut8 (
    .clk(clk), .rst(rst), .d_i(d_i), .valid_i(valid_i), .overlap_i(overlap_i),
    .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i), .cnt_clr_i(cnt_clr_i),
    .pattern_o(p8), .match_cnt_o(c8), .busy_o(b8));

  pattern_det_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .d_i(d_i), .valid_i(valid_i), .overlap_i(overlap_i),
    .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i), .cnt_clr_i(cnt_clr_i),
    .pattern_o(p2), .match_cnt_o(c2), .busy_o(b2));

  int tests = 0, fails = 0;

  // Model: the bits consumed since the last restart, newest at the back
  bit         mq[$];
  logic [4:0] mpat = PINIT;
  int         mc8 = 0, mc2 = 0;
  bit         mp = 0;

  function automatic logic [4:0] qpack();
    logic [4:0] v = '0;
    foreach (mq[i]) v = {v[3:0], mq[i]};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit dd, input bit ov,
                     input bit ld, input logic [4:0] lp, input bit cl);
    rst = r; valid_i = v; d_i = dd; overlap_i = ov;
    cfg_load_i = ld; cfg_pattern_i = lp; cnt_clr_i = cl;
    mp = 0;
    if (r) begin
      mq.delete(); mpat = PINIT; mc8 = 0; mc2 = 0;
    end else begin
      if (ld) begin
        mpat = lp; mq.delete();
      end else if (v) begin
        mq.push_back(dd);
        if (mq.size() > 5) void'(mq.pop_front());
        if (mq.size() == 5 && qpack() == mpat) begin
          mp = 1;
          if (!ov) mq.delete();
        end
      end
      if (cl) begin
        mc8 = 0; mc2 = 0;
      end else if (mp) begin
        if (mc8 < 255) mc8++;
        if (mc2 < 3)   mc2++;
      end
    end
    @(posedge clk); #1;
    chk("pulse8", p8, mp);
    chk("busy8",  b8, mq.size() != 0);
    chk("cnt8",   c8, mc8);
    chk("pulse2", p2, mp);
    chk("busy2",  b2, mq.size() != 0);
    chk("cnt2",   c2, mc2);
  endtask

  task automatic bits5(input logic [4:0] b, input bit ov);
    for (int i = 4; i >= 0; i--) cyc(0, 1, b[i], ov, 0, 5'b0, 0);
  endtask

  typedef struct {
    bit r, v, d, ov, ld, cl;
    logic [4:0] lp;
    bit ep, eb;
    int ec;
  } vec_t;

  vec_t tv[$];
  int   np;

  initial begin
    // reset, default pattern 0,0,1,0,1 non-overlapping, then load-with-valid mid-pattern
    tv.push_back('{1,0,0,0,0,0, 5'b0,     0,0,0});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,0});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,0});
    tv.push_back('{0,1,1,0,0,0, 5'b0,     0,1,0});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,0});
    tv.push_back('{0,1,1,0,0,0, 5'b0,     1,0,1});
    tv.push_back('{0,0,0,0,0,0, 5'b0,     0,0,1});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,1,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,1,0,1,0, 5'b10101, 0,0,1});
    tv.push_back('{0,1,1,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,1,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,0,0,0,0, 5'b0,     0,1,1});
    tv.push_back('{0,1,1,0,0,0, 5'b0,     1,0,2});

    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    foreach (tv[i]) begin
      cyc(tv[i].r, tv[i].v, tv[i].d, tv[i].ov, tv[i].ld, tv[i].lp, tv[i].cl);
      chk("tbl_pulse", p8, tv[i].ep);
      chk("tbl_busy",  b8, tv[i].eb);
      chk("tbl_cnt",   c8, tv[i].ec);
    end

    // 1010101 against 10101, overlapping then non-overlapping
    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    cyc(0, 0, 0, 0, 1, 5'b10101, 0);
    bits5(5'b10101, 1); cyc(0, 1, 0, 1, 0, 5'b0, 0); cyc(0, 1, 1, 1, 0, 5'b0, 0);
    chk("ov1_cnt", c8, 2);
    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    cyc(0, 0, 0, 0, 1, 5'b10101, 0);
    bits5(5'b10101, 0); cyc(0, 1, 0, 0, 0, 5'b0, 0); cyc(0, 1, 1, 0, 0, 5'b0, 0);
    chk("ov0_cnt", c8, 1);

    // gaps of three idle cycles between bits
    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    np = 0;
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 1, PINIT[i], 0, 0, 5'b0, 0);
      np += p8;
      if (i == 0) chk("gap_last_pulse", p8, 1);
      for (int k = 0; k < 3; k++) begin
        cyc(0, 0, 0, 0, 0, 5'b0, 0);
        np += p8;
      end
    end
    chk("gap_pulses", np, 1);

    // reset discards a partial pattern
    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    cyc(0, 1, 0, 0, 0, 5'b0, 0); cyc(0, 1, 0, 0, 0, 5'b0, 0);
    cyc(0, 1, 1, 0, 0, 5'b0, 0); cyc(0, 1, 0, 0, 0, 5'b0, 0);
    cyc(1, 1, 1, 0, 0, 5'b0, 0);
    chk("rst_busy", b8, 0);
    cyc(0, 1, 1, 0, 0, 5'b0, 0);
    chk("rst_pulse", p8, 0);
    chk("rst_busy1", b8, 1);
    cyc(0, 1, 0, 0, 0, 5'b0, 0); cyc(0, 1, 1, 0, 0, 5'b0, 0);
    cyc(0, 1, 0, 0, 0, 5'b0, 0); cyc(0, 1, 1, 0, 0, 5'b0, 0);
    chk("rst_cnt", c8, 0);

    // 2-bit counter saturation, clear on a match edge
    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    for (int m = 0; m < 5; m++) bits5(PINIT, 0);
    chk("sat_cnt2", c2, 3);
    chk("sat_cnt8", c8, 5);
    for (int i = 4; i >= 1; i--) cyc(0, 1, PINIT[i], 0, 0, 5'b0, 0);
    cyc(0, 1, PINIT[0], 0, 0, 5'b0, 1);
    chk("clr_pulse", p2, 1);
    chk("clr_cnt2", c2, 0);

    // random traffic
    cyc(1, 0, 0, 0, 0, 5'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [4:0] lp;
      r  = int'($urandom_range(0, 199));
      lp = 5'($urandom);
      cyc(r == 0, $urandom_range(0, 3) != 0, 1'($urandom), (i / 300) % 2 == 1,
          r inside {[1:3]}, lp, r inside {[4:5]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pattern_det_param.md
PATTERN_DET_PARAM -- requirements
Module: pattern_det_param

Interface
REQ-001 Parameter PAT_LEN, default 5, pattern length in bits; legal range 2..16.
REQ-002 Parameter PAT_INIT, default 5'b00101, reset pattern; MSB is the first bit received (B=0, C=1: B,B,C,B,C).
REQ-003 Parameter CNT_W, default 8, match counter width.
REQ-004 Single clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 d_i  input  1  serial data bit.
REQ-008 valid_i  input  1  d_i qualifier; a bit is consumed only when high.
REQ-009 overlap_i  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-010 cfg_load_i  input  1  load new pattern.
REQ-011 cfg_pattern_i  input  PAT_LEN  pattern value captured on cfg_load_i.
REQ-012 cnt_clr_i  input  1  clear match counter.
REQ-013 pattern_o  output  1  one-cycle match pulse.
REQ-014 match_cnt_o  output  CNT_W  saturating count of matches.
REQ-015 busy_o  output  1  high while history holds at least one bit (state != EMPTY).

Function
REQ-016 Datapath: PAT_LEN-bit history shift register, PAT_LEN-bit pattern register, fill counter 0..PAT_LEN.
REQ-017 Consumed bit: history <= {history[PAT_LEN-2:0], d_i}; fill increments, saturating at PAT_LEN.
REQ-018 Cycles with valid_i=0: history, fill and state hold; pattern_o=0.
REQ-019 FSM states: EMPTY (fill=0), FILLING (0<fill<PAT_LEN), ARMED (fill=PAT_LEN after the current bit).
REQ-020 Transitions: EMPTY->FILLING on first consumed bit; FILLING->ARMED when fill reaches PAT_LEN; ARMED->EMPTY on non-overlap match; any->EMPTY on cfg_load_i or rst.
REQ-021 Match: on an edge consuming a bit where the post-shift history equals the pattern register and the post-shift fill equals PAT_LEN, pattern_o is registered high for exactly one cycle.
REQ-022 Latency: pattern_o is visible the cycle after the edge sampling the final pattern bit; otherwise pattern_o=0.
REQ-023 overlap_i=1: after a match, history and fill are retained; the next match may reuse trailing bits.
REQ-024 overlap_i=0: after a match, fill is cleared to 0 (state EMPTY); the next match needs PAT_LEN fresh bits.
REQ-025 overlap_i is sampled on every consumed bit; changes take effect immediately.
REQ-026 cfg_load_i=1: pattern register <= cfg_pattern_i; fill <= 0; state <= EMPTY; pattern_o <= 0; a valid bit in the same cycle is dropped.
REQ-027 match_cnt_o increments by 1 per match and saturates at 2^CNT_W-1 with no wrap.
REQ-028 cnt_clr_i clears match_cnt_o to 0 and wins over a simultaneous increment; pattern_o still pulses.
REQ-029 cfg_load_i does not affect match_cnt_o.

Reset
REQ-030 On rst: pattern_o=0, match_cnt_o=0, busy_o=0, history=0, fill=0, state=EMPTY, pattern register=PAT_INIT.
REQ-031 rst has priority over cfg_load_i, cnt_clr_i and valid_i; a partial pattern in progress is discarded.

Structure
REQ-032 Package pattern_det_pkg holds the FSM state encoding (EMPTY, FILLING, ARMED), symbols B=1'b0 and C=1'b1, and the default PAT_INIT.
REQ-033 One sub-module, pattern_det_sat_cnt (width CNT_W; inc, clr, sync rst), implements REQ-027/028.
REQ-034 Top-level RTL has no $display statements and no unreachable state without a default transition to EMPTY.

Verification
REQ-035 Defaults, overlap_i=0, valid stream 0,0,1,0,1 -> pattern_o=1 one cycle after the 5th bit; match_cnt_o=1.
REQ-036 Load 5'b10101, stream 1,0,1,0,1,0,1: overlap_i=1 -> pulses after bits 5 and 7 (count 2); overlap_i=0 -> pulse after bit 5 only (count 1).
REQ-037 Stream 0,0,1,0,1 with valid_i=0 gaps of 3 cycles between bits -> exactly one pulse, after the 5th valid bit.
REQ-038 After 4 bits of 0,0,1,0, assert rst, then send 1 -> no pulse; busy_o=1 with fill=1 after the 1.
REQ-039 CNT_W=2, 5 non-overlapping matches -> match_cnt_o stops at 3; cnt_clr_i on the 6th match edge -> count 0, pattern_o=1.
REQ-040 cfg_load_i and valid_i together mid-pattern -> bit dropped, busy_o=0, new pattern matched only from fresh bits.
